// File: rtl/pe_result_drain.sv
// Clears a PE column, captures each PE result at its skewed completion cycle, then streams the words out (valid/ready, stalls hold data).
// Start-to-done is 2+(k_len+NUM_PE)+NUM_PE cycles minimum; optional DRAIN_RELU_EN zeroes negative words on capture.
module pe_result_drain #(
  parameter int DWIDTH    = 8,
  parameter int NUM_PE    = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_WIDTH-1:0]     k_len,
  input  logic [NUM_PE*DWIDTH-1:0] pe_out_c,
  output logic                     pe_clear,
  output logic                     busy,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     done
);

  localparam int CW = CNT_WIDTH + 1;
  localparam int RW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, SEND} state_t;

  state_t            state;
  logic [CW-1:0]     c;
  logic [CW-1:0]     k_q;
  logic [RW-1:0]     r;
  logic [RW-1:0]     r_inc;
  logic              last_cap;
  logic [DWIDTH-1:0] res_buf [NUM_PE];
  logic [DWIDTH-1:0] buf_nxt [NUM_PE];
  logic [DWIDTH-1:0] word    [NUM_PE];

  // PE i finishes i cycles after PE 0 because of the systolic skew.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      word[i] = pe_out_c[i*DWIDTH +: DWIDTH];
`ifdef DRAIN_RELU_EN
      if (word[i][DWIDTH-1]) word[i] = '0;
`endif
      buf_nxt[i] = res_buf[i];
      if (state == ACCUM && c == k_q + CW'(i)) buf_nxt[i] = word[i];
    end
  end

  assign last_cap = (c == k_q + CW'(NUM_PE - 1));
  assign r_inc    = r + RW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      c         <= '0;
      k_q       <= '0;
      r         <= '0;
      pe_clear  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) res_buf[i] <= '0;
    end else begin
      done     <= 1'b0;
      pe_clear <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) res_buf[i] <= buf_nxt[i];
      case (state)
        IDLE: begin
          if (start) begin
            k_q      <= {1'b0, k_len};
            state    <= CLEAR;
            pe_clear <= 1'b1;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          c     <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          c <= c + CW'(1);
          if (last_cap) begin
            // buf_nxt[0] covers NUM_PE==1, where the capture lands on this same edge.
            state     <= SEND;
            r         <= '0;
            out_valid <= 1'b1;
            out_data  <= buf_nxt[0];
            out_last  <= (NUM_PE == 1);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (r == RW'(NUM_PE - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              r        <= r_inc;
              out_data <= res_buf[r_inc];
              out_last <= (r_inc == RW'(NUM_PE - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: table of drains plus backpressure, restart-ignore and mid-SEND reset sequences.
module tb_pe_result_drain;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int KW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [KW-1:0]    k_len;
  logic [NP*DW-1:0] pe_out_c;
  logic             pe_clear, busy, out_valid, out_ready, out_last, done;
  logic [DW-1:0]    out_data;

  always #5 clk = ~clk;

  pe_result_drain #(.DWIDTH(DW), .NUM_PE(NP), .CNT_WIDTH(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .pe_out_c(pe_out_c),
    .pe_clear(pe_clear), .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PE column model: slice i shows v[i] from cycle c=k+i, or a[i] from c=k+i+1 when skew is set.
  int                 cur_c = -100;
  int                 clears = 0;
  int                 mk = 0;
  bit                 mskew = 0;
  logic [NP-1:0][7:0] mv = '0;
  logic [NP-1:0][7:0] ma = '0;

  always @(negedge clk) begin
    if (!reset) cur_c = -100;
    else if (pe_clear) begin cur_c = -1; clears++; end
    else if (cur_c > -100) cur_c++;
    for (int i = 0; i < NP; i++) begin
      if (cur_c >= 0 && mskew && cur_c > mk + i) pe_out_c[i*DW +: DW] = ma[i];
      else if (cur_c >= 0 && cur_c >= mk + i)    pe_out_c[i*DW +: DW] = mv[i];
      else                                       pe_out_c[i*DW +: DW] = '0;
    end
  end

  typedef struct {
    int                 k;
    logic [NP-1:0][7:0] v;
    logic [NP-1:0][7:0] a;
    bit                 skew;
    logic [NP-1:0][7:0] e;
  } vec_t;

  vec_t vt [5];

  task automatic run_vec(input vec_t x, input string tag);
    int n;
    int cl0;
    mk = x.k; mv = x.v; ma = x.a; mskew = x.skew;
    cl0 = clears;
    out_ready = 1'b1;
    k_len = KW'(x.k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clear"}, pe_clear, 1);
    check({tag, "_busy"}, busy, 1);
    n = 1;
    while (!out_valid && n < 600) begin @(negedge clk); n++; end
    check({tag, "_latency"}, n, x.k + 6);
    for (int j = 0; j < NP; j++) begin
      check($sformatf("%s_valid%0d", tag, j), out_valid, 1);
      check($sformatf("%s_data%0d", tag, j), out_data, x.e[j]);
      check($sformatf("%s_last%0d", tag, j), out_last, (j == NP - 1));
      check($sformatf("%s_nodone%0d", tag, j), done, 0);
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_vlow"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_done1"}, done, 0);
    check({tag, "_clears"}, clears - cl0, 1);
  endtask

  initial begin
    logic [7:0] pat_rdy [7];
    logic [7:0] pat_dat [7];
    int n, words, dones;

    vt[0].k = 3;   vt[0].v = {8'd13, 8'd12, 8'd11, 8'd10}; vt[0].a = '0; vt[0].skew = 0;
    vt[0].e = {8'd13, 8'd12, 8'd11, 8'd10};
    vt[1].k = 5;   vt[1].v = {8'h24, 8'h23, 8'h22, 8'h21}; vt[1].a = {4{8'h6E}}; vt[1].skew = 1;
    vt[1].e = {8'h24, 8'h23, 8'h22, 8'h21};
    vt[2].k = 0;   vt[2].v = '0; vt[2].a = '0; vt[2].skew = 0; vt[2].e = '0;
    vt[3].k = 2;   vt[3].v = {8'h00, 8'hFF, 8'h7F, 8'h85}; vt[3].a = '0; vt[3].skew = 0;
`ifdef DRAIN_RELU_EN
    vt[3].e = {8'h00, 8'h00, 8'h7F, 8'h00};
`else
    vt[3].e = {8'h00, 8'hFF, 8'h7F, 8'h85};
`endif
    vt[4].k = 255; vt[4].v = {8'd4, 8'd3, 8'd2, 8'd1}; vt[4].a = {4{8'h55}}; vt[4].skew = 1;
    vt[4].e = {8'd4, 8'd3, 8'd2, 8'd1};

    reset = 1'b0; start = 1'b0; out_ready = 1'b0; k_len = '0;
    #2;
    check("rst_clear", pe_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(vt[v], $sformatf("vec%0d", v));

    // Backpressure: ready pattern 1,0,0,1,0,1,1 across the SEND cycles.
    pat_rdy = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
    pat_dat = '{8'h31, 8'h32, 8'h32, 8'h32, 8'h33, 8'h33, 8'h34};
    mk = 1; mskew = 0; mv = {8'h34, 8'h33, 8'h32, 8'h31};
    out_ready = 1'b0; k_len = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_latency", n, 7);
    for (int j = 0; j < 7; j++) begin
      check($sformatf("bp_valid%0d", j), out_valid, 1);
      check($sformatf("bp_data%0d", j), out_data, pat_dat[j]);
      check($sformatf("bp_last%0d", j), out_last, (j == 6));
      check($sformatf("bp_nodone%0d", j), done, 0);
      out_ready = pat_rdy[j][0];
      @(negedge clk);
    end
    check("bp_done", done, 1);
    check("bp_vlow", out_valid, 0);
    @(negedge clk);

    // k_len=0 with a second start during ACCUM that must be ignored.
    mk = 0; mv = '0; mskew = 0;
    out_ready = 1'b1; k_len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; k_len = 8'd9;
    @(negedge clk);
    start = 1'b0;
    words = 0; dones = 0;
    for (int j = 0; j < 20; j++) begin
      if (out_valid) begin
        check($sformatf("k0_data%0d", words), out_data, 0);
        words++;
      end
      if (done) dones++;
      @(negedge clk);
    end
    check("k0_words", words, 4);
    check("k0_dones", dones, 1);
    check("k0_idle", busy, 0);

    // Asynchronous reset while word 1 is on the bus.
    mk = 3; mv = {8'd13, 8'd12, 8'd11, 8'd10}; mskew = 0;
    out_ready = 1'b1; k_len = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    check("rs_word1", out_data, 8'd11);
    #2 reset = 1'b0;
    #1;
    check("rs_valid", out_valid, 0);
    check("rs_data", out_data, 0);
    check("rs_last", out_last, 0);
    check("rs_busy", busy, 0);
    check("rs_done", done, 0);
    check("rs_clear", pe_clear, 0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int j = 0; j < 6; j++) begin
      if (done || out_valid) dones++;
      @(negedge clk);
    end
    check("rs_quiet", dones, 0);
    run_vec(vt[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Result-side companion to the systolic processing element. For one column of `NUM_PE` PEs it issues the accumulator clear, counts MAC cycles, and captures each PE's `out_c` at that PE's skewed completion cycle. It then serializes the captured words over a valid/ready stream toward the output buffer. It sits at the bottom edge of each PE column and reads what the PE MACs have written.

## Interface

Parameters:
- `DWIDTH`, 8: width of one PE result word and of the output stream.
- `NUM_PE`, 4: PEs in the drained column (≥1).
- `CNT_WIDTH`, 8: width of `k_len` and of the internal cycle counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `start`  in  1  begin a drain; sampled only in IDLE.
- `k_len`  in  CNT_WIDTH  MAC operand count per PE; sampled with `start`.
- `pe_out_c`  in  NUM_PE*DWIDTH  flat PE result bus; slice i = `[i*DWIDTH +: DWIDTH]` = PE i (PE 0 nearest feeder).
- `pe_clear`  out  1  high for one cycle to clear PE accumulators (drives the PE reset input).
- `busy`  out  1  high in any state except IDLE.
- `out_data`  out  DWIDTH  result word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the word when high with `out_valid`.
- `out_last`  out  1  high with the word from PE `NUM_PE-1`.
- `done`  out  1  one-cycle pulse when the drain completes.

## Operation

- States: IDLE, CLEAR, ACCUM, SEND.
- IDLE:
  - `start`=1 latches `k_len` and moves to CLEAR.
  - `start` is ignored in every other state.
- CLEAR:
  - Lasts exactly one cycle with `pe_clear`=1.
  - Counter `c` is set to 0, then the block moves to ACCUM.
- ACCUM:
  - `c` increments every cycle.
  - At the end of cycle `c == k_len + i`, slice i is captured into `buf[i]` for 0 ≤ i < NUM_PE.
  - After the capture at `c == k_len + NUM_PE - 1`, the block moves to SEND with read index `r` = 0.
  - Counter width is `CNT_WIDTH+1` internally, so `k_len + NUM_PE - 1` never wraps.
- SEND:
  - `out_valid`=1 and `out_data`=`buf[r]`.
  - On handshake (`out_valid & out_ready`): `r` increments.
  - On the handshake at `r == NUM_PE-1`: return to IDLE and pulse `done` in the following cycle.
  - `out_data` and `out_last` hold stable while `out_valid & !out_ready`.
- `k_len`=0 is legal: every capture sees the cleared accumulator, so all words are 0.
- Reset mid-operation, at any state: immediate return to IDLE. Captured words are discarded and no `done` pulse is issued.
- Reset values: `pe_clear`=0, `busy`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `done`=0. Buffers and counters are cleared to 0.

## Timing

- `start` is sampled high at edge t:
  - `pe_clear`=1 and `busy`=1 during cycle t+1.
  - ACCUM `c`=0 in cycle t+2.
- Last capture at the end of ACCUM cycle `k_len+NUM_PE-1`. `out_valid` rises the next cycle.
- With `out_ready` held high: one word per cycle, NUM_PE cycles in SEND.
- `done` is high for exactly the one cycle after the final handshake, with `busy`=0 in that cycle.
- A new `start` is accepted in the same cycle `done` is high.
- Minimum drain length, start to done: 2 + (k_len + NUM_PE) + NUM_PE cycles.

## Configuration

- `DRAIN_RELU_EN` defined: each captured word is treated as signed two's complement. Negative words (MSB=1) are stored as 0; non-negative words are stored unchanged.
- Not defined: words are stored bit-exact from `pe_out_c`.

## Test plan

- Basic drain, NUM_PE=4, k_len=3:
  - Stimulus: PE model drives slice i = 10+i from cycle `c=k_len+i` onward, 0 before; `out_ready`=1.
  - Required: words 10,11,12,13 on consecutive cycles; `out_last` on 13; `done` one cycle later; `pe_clear` exactly one pulse.
- Skew check:
  - Stimulus: slice i changes to a different value one cycle after its capture point.
  - Required: the pre-change values are output, proving per-PE capture timing.
- Backpressure:
  - Stimulus: `out_ready` toggles 1,0,0,1,0,1,1.
  - Required: each word held stable while stalled; 4 words in order with no loss or duplication; `done` only after the 4th handshake.
- `k_len`=0 and start-while-busy:
  - Stimulus: k_len=0; `start` pulsed again during ACCUM.
  - Required: four 0 words; the second `start` is ignored; exactly one `done`.
- Reset mid-SEND:
  - Stimulus: `reset` driven low asynchronously after word 1.
  - Required: all outputs 0 immediately; no `done`; a fresh `start` yields a correct full drain.
- `DRAIN_RELU_EN`:
  - Stimulus: slices 0x85, 0x7F, 0xFF, 0x00.
  - Required with macro: output 0x00, 0x7F, 0x00, 0x00.
  - Required without macro: output 0x85, 0x7F, 0xFF, 0x00.
